imem_loader: RTL
================

# imem_loader

Boot-time program loader that writes the instruction memory which the instruction cache reads. It accepts a byte stream, packs it into 128-bit blocks in the instruction-cache block layout and issues block writes to the instruction memory over a write/busywait handshake. It holds the CPU in reset until the whole program is in memory.

## Interface

Parameters:
- MAX_BYTES, 1024: instruction memory size in bytes (64 blocks of 16 bytes).

Ports:
- CLK  in  1  clock; all state changes on the posedge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- LENGTH  in  11  program length in bytes; latched on START.
- BYTE_VALID  in  1  BYTE_IN holds a valid byte.
- BYTE_IN  in  8  program byte, in ascending address order.
- BYTE_READY  out  1  loader accepts a byte this cycle.
- IMEM_WRITE  out  1  block-write request to instruction memory.
- IMEM_ADDRESS  out  6  block address (byte address [9:4]).
- IMEM_WRITEDATA  out  128  block data.
- IMEM_BUSYWAIT  in  1  memory busy.
- CPU_RESET  out  1  reset to the CPU; high until the load completes.
- DONE  out  1  load complete.

## Operation

- States: IDLE, COLLECT, WRITE, DONE.
- Packing: byte offset o (0..15) within a block goes to IMEM_WRITEDATA[32*o[3:2] + 8*(3-o[1:0]) +: 8]. Word w sits at bits [32w+31:32w], and the lowest-addressed byte of each word is its MSB (big-endian instruction words).
- IDLE: on START, latch LENGTH and clear the byte count, block buffer and block address.
  - If LENGTH = 0, go to DONE.
  - Otherwise go to COLLECT.
  - LENGTH > MAX_BYTES is clamped to MAX_BYTES.
- COLLECT:
  - BYTE_READY = 1.
  - A byte is accepted on a posedge where BYTE_VALID && BYTE_READY.
  - Go to WRITE when the 16th byte of the block is accepted or the last program byte is accepted.
  - Unfilled bytes of a final partial block are 0x00.
- WRITE:
  - BYTE_READY = 0.
  - IMEM_WRITE = 1, with IMEM_ADDRESS and IMEM_WRITEDATA held stable.
  - The write completes on the first posedge at which IMEM_BUSYWAIT = 0 after IMEM_BUSYWAIT has been sampled 1 during this write.
  - On completion, IMEM_WRITE drops, the block address increments and the buffer clears to zero.
  - The next state is DONE if all bytes are written, otherwise COLLECT.
- DONE:
  - DONE = 1 and CPU_RESET = 0.
  - START in DONE restarts the load: DONE = 0 and CPU_RESET = 1 from the next cycle, same as from IDLE.
- START outside IDLE/DONE is ignored.
- BYTE_VALID outside COLLECT is ignored; no byte is consumed.

## Timing

- Reset values:
  - state = IDLE.
  - BYTE_READY = 0, IMEM_WRITE = 0, IMEM_ADDRESS = 0, IMEM_WRITEDATA = 0.
  - CPU_RESET = 1, DONE = 0.
  - Internal byte count = 0.
- RESET mid-load: the next posedge forces the reset values. The partially written memory is left as is, and no write is in flight afterwards.
- START to BYTE_READY: 1 cycle (BYTE_READY is high in the cycle after the START posedge).
- Throughput: 1 byte per cycle in COLLECT. A 16-byte block takes 16 cycles plus the write handshake.
- IMEM_WRITE asserts in the cycle after the posedge that accepts the block's last byte.
- The memory asserts IMEM_BUSYWAIT on the posedge after it sees IMEM_WRITE. The loader never drops IMEM_WRITE before it has seen busywait high.
- The final write completes at posedge T. DONE = 1 and CPU_RESET = 0 from T; both are registered outputs.
- Final block address = ceil(min(LENGTH, MAX_BYTES)/16) - 1. There is no wrap past block 63.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan

- **Reset:** assert RESET for 2 cycles → CPU_RESET = 1, DONE = 0, IMEM_WRITE = 0, BYTE_READY = 0. START with LENGTH = 0 → DONE = 1 and CPU_RESET = 0 after 1 cycle, with no IMEM_WRITE pulse.
- **Exact single block:** LENGTH = 16, stream bytes 0x00..0x0F with an echo memory model of 3-cycle busywait.
  - Exactly one write to IMEM_ADDRESS = 0.
  - IMEM_WRITEDATA[31:0] = 0x00010203 and [127:96] = 0x0C0D0E0F.
  - DONE = 1 after the write completes.
- **Partial last block:** LENGTH = 24 (6 instructions, e.g. loadi 1 0x02 = 0x00010002 first).
  - Block 0 is written with 16 bytes.
  - Block 1 is written with words 0–1 from the stream and words 2–3 = 0.
  - Then DONE = 1.
- **Stall and backpressure:** drop BYTE_VALID for random cycles and hold IMEM_BUSYWAIT = 1 for 10 cycles.
  - No byte is lost or duplicated.
  - IMEM_WRITE and its data stay stable during busywait.
  - BYTE_READY = 0 throughout WRITE.
- **Reset mid-load:** LENGTH = 64, assert RESET after byte 20 (during block 1 COLLECT).
  - Outputs return to reset values on the next posedge.
  - A following START with LENGTH = 16 writes block 0 only.
- **Full memory and clamp:** LENGTH = 1100.
  - 64 writes to blocks 0..63 in order, with no address wrap.
  - DONE = 1 after 1024 bytes; BYTE_READY = 0 afterwards.
  - A START in DONE restarts: CPU_RESET = 1 again.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into 128-bit instruction-cache blocks and writes
// them to instruction memory, holding the CPU in reset until the program is loaded.
module imem_loader #(
    parameter int MAX_BYTES = 1024
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic [10:0]  LENGTH,
    input  logic         BYTE_VALID,
    input  logic [7:0]   BYTE_IN,
    output logic         BYTE_READY,
    output logic         IMEM_WRITE,
    output logic [5:0]   IMEM_ADDRESS,
    output logic [127:0] IMEM_WRITEDATA,
    input  logic         IMEM_BUSYWAIT,
    output logic         CPU_RESET,
    output logic         DONE
);
    localparam logic [10:0] MAX_LEN = 11'(MAX_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [10:0]   r_len;
    logic [10:0]   r_count;
    logic [5:0]    r_addr;
    logic [127:0]  r_buf;
    logic          r_seen_busy;

    logic          w_start;
    logic          w_accept;
    logic          w_block_full;
    logic          w_last_byte;
    logic          w_write_done;
    logic          w_all_written;
    logic [10:0]   w_len_clamped;
    logic [15:0]   w_lane_sel;

    assign w_start       = START && (r_state == S_IDLE || r_state == S_DONE);
    assign w_accept      = (r_state == S_COLLECT) && BYTE_VALID;
    assign w_block_full  = (r_count[3:0] == 4'hF);
    assign w_last_byte   = ((r_count + 11'd1) == r_len);
    assign w_all_written = (r_count == r_len);
    assign w_len_clamped = (LENGTH > MAX_LEN) ? MAX_LEN : LENGTH;
    // A write only completes once busywait has been seen high and then low again.
    assign w_write_done  = (r_state == S_WRITE) && r_seen_busy && !IMEM_BUSYWAIT;

    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
        assign w_lane_sel[gi] = w_accept && (r_count[3:0] == 4'(gi));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_state_next = (w_len_clamped == 11'd0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_accept && (w_block_full || w_last_byte)) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_write_done) begin
                    w_state_next = w_all_written ? S_DONE : S_COLLECT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        BYTE_READY     = (r_state == S_COLLECT);
        IMEM_WRITE     = (r_state == S_WRITE);
        DONE           = (r_state == S_DONE);
        CPU_RESET      = (r_state != S_DONE);
        IMEM_ADDRESS   = r_addr;
        IMEM_WRITEDATA = r_buf;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_len       <= '0;
            r_count     <= '0;
            r_addr      <= '0;
            r_buf       <= '0;
            r_seen_busy <= 1'b0;
        end else if (w_start) begin
            r_len       <= w_len_clamped;
            r_count     <= '0;
            r_addr      <= '0;
            r_buf       <= '0;
            r_seen_busy <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count <= r_count + 11'd1;
            end
            // Big-endian words: lowest-addressed byte of a word lands in its MSB.
            for (int i = 0; i < 16; i++) begin
                if (w_lane_sel[i]) begin
                    r_buf[32*(i/4) + 8*(3-(i%4)) +: 8] <= BYTE_IN;
                end
            end
            if (w_write_done) begin
                r_seen_busy <= 1'b0;
                r_buf       <= '0;
                // The last block's address is kept so the final address never wraps.
                if (!w_all_written) begin
                    r_addr <= r_addr + 6'd1;
                end
            end else if (r_state == S_WRITE && IMEM_BUSYWAIT) begin
                r_seen_busy <= 1'b1;
            end
        end
    end
endmodule
